// File: rtl/lstm_seq_ctrl.sv
// Run sequencer for the LSTM accelerator: weight loads, then per-timestep input write, calc and output read.
// Optional LSTM_SEQ_KEEP_WEIGHTS_EN lets a run skip the weight loads when weights are already resident.
module lstm_seq_ctrl #(
    parameter int MAIN_MEM_ADD_LEN = 11,
    parameter int FEATURES         = 4,
    parameter int WEIGHTS          = 64,
    parameter int CYCLES           = 10,
    localparam int STEP_W          = (CYCLES > 1) ? $clog2(CYCLES) : 1
) (
    input  logic                        fpga_clk,
    input  logic                        reset_n,
    input  logic                        run,
    input  logic                        keep_weights,
    input  logic                        xfer_done,
    input  logic                        calc_done,
    output logic [2:0]                  op_mode,
    output logic                        direct,
    output logic [MAIN_MEM_ADD_LEN-1:0] main_mem_count,
    output logic [MAIN_MEM_ADD_LEN-1:0] main_mem_first_address,
    output logic                        start,
    output logic                        calc_start,
    output logic [STEP_W-1:0]           step_idx,
    output logic                        busy,
    output logic                        done
);

    localparam int AW = MAIN_MEM_ADD_LEN;

    localparam logic [AW-1:0] IN_FIRST  = '0;
    localparam logic [AW-1:0] W1_FIRST  = AW'(FEATURES * CYCLES);
    localparam logic [AW-1:0] W2_FIRST  = W1_FIRST + AW'(WEIGHTS);
    localparam logic [AW-1:0] OUT_FIRST = W2_FIRST + AW'(WEIGHTS);
    localparam logic [AW-1:0] FEAT_CNT  = AW'(FEATURES);
    localparam logic [AW-1:0] WGT_CNT   = AW'(WEIGHTS);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(CYCLES - 1);

    // The output bank must end inside the addressable main memory.
    localparam longint MAP_END = 2 * longint'(FEATURES) * longint'(CYCLES) + 2 * longint'(WEIGHTS);
    generate
        if (MAP_END > (longint'(1) << MAIN_MEM_ADD_LEN)) begin : g_map_check
            $fatal(1, "lstm_seq_ctrl: memory map does not fit in MAIN_MEM_ADD_LEN bits");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE    = 3'b000,
        INIT_W1 = 3'b001,
        INIT_W2 = 3'b010,
        W_IN    = 3'b011,
        CALC    = 3'b100,
        R_OUT   = 3'b101,
        DONE    = 3'b110
    } state_t;

    state_t state;

    function automatic logic [AW-1:0] in_addr(input logic [STEP_W-1:0] s);
        return IN_FIRST + AW'(s) * FEAT_CNT;
    endfunction

    function automatic logic [AW-1:0] out_addr(input logic [STEP_W-1:0] s);
        return OUT_FIRST + AW'(s) * FEAT_CNT;
    endfunction

    logic skip_load;
`ifdef LSTM_SEQ_KEEP_WEIGHTS_EN
    logic weights_valid;
    assign skip_load = keep_weights & weights_valid;
`else
    logic unused_keep_weights;
    assign unused_keep_weights = keep_weights;
    assign skip_load = 1'b0;
`endif

    assign op_mode = state;

    // Completions are ignored while the kick of the current state is still high.
    always_ff @(posedge fpga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state                  <= IDLE;
            direct                 <= 1'b0;
            main_mem_count         <= '0;
            main_mem_first_address <= '0;
            start                  <= 1'b0;
            calc_start             <= 1'b0;
            step_idx               <= '0;
            busy                   <= 1'b0;
            done                   <= 1'b0;
`ifdef LSTM_SEQ_KEEP_WEIGHTS_EN
            weights_valid          <= 1'b0;
`endif
        end else begin
            start      <= 1'b0;
            calc_start <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (run) begin
                        busy   <= 1'b1;
                        start  <= 1'b1;
                        direct <= 1'b0;
                        if (skip_load) begin
                            state                  <= W_IN;
                            main_mem_count         <= FEAT_CNT;
                            main_mem_first_address <= in_addr('0);
                        end else begin
                            state                  <= INIT_W1;
                            main_mem_count         <= WGT_CNT;
                            main_mem_first_address <= W1_FIRST;
                        end
                    end
                end
                INIT_W1: begin
                    if (xfer_done && !start) begin
                        state                  <= INIT_W2;
                        start                  <= 1'b1;
                        main_mem_count         <= WGT_CNT;
                        main_mem_first_address <= W2_FIRST;
                    end
                end
                INIT_W2: begin
                    if (xfer_done && !start) begin
                        state                  <= W_IN;
                        start                  <= 1'b1;
                        main_mem_count         <= FEAT_CNT;
                        main_mem_first_address <= in_addr(step_idx);
`ifdef LSTM_SEQ_KEEP_WEIGHTS_EN
                        weights_valid          <= 1'b1;
`endif
                    end
                end
                W_IN: begin
                    if (xfer_done && !start) begin
                        state                  <= CALC;
                        calc_start             <= 1'b1;
                        direct                 <= 1'b0;
                        main_mem_count         <= '0;
                        main_mem_first_address <= '0;
                    end
                end
                CALC: begin
                    if (calc_done && !calc_start) begin
                        state                  <= R_OUT;
                        start                  <= 1'b1;
                        direct                 <= 1'b1;
                        main_mem_count         <= FEAT_CNT;
                        main_mem_first_address <= out_addr(step_idx);
                    end
                end
                R_OUT: begin
                    if (xfer_done && !start) begin
                        direct <= 1'b0;
                        if (step_idx == LAST_STEP) begin
                            state                  <= DONE;
                            done                   <= 1'b1;
                            main_mem_count         <= '0;
                            main_mem_first_address <= '0;
                        end else begin
                            state                  <= W_IN;
                            start                  <= 1'b1;
                            step_idx               <= step_idx + 1'b1;
                            main_mem_count         <= FEAT_CNT;
                            main_mem_first_address <= in_addr(step_idx + 1'b1);
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    step_idx <= '0;
                end
                default: begin
                    state                  <= IDLE;
                    busy                   <= 1'b0;
                    step_idx               <= '0;
                    direct                 <= 1'b0;
                    main_mem_count         <= '0;
                    main_mem_first_address <= '0;
                end
            endcase
        end
    end

endmodule
